// File: rtl/fp16_pkg.sv
// Shared types and constants for the FP16 operand unpack front end.
// Field widths, FSM states, operand classes and the sticky right-shift step.
package fp16_pkg;

    localparam int EXP_W         = 5;
    localparam int FRAC_W        = 10;
    localparam int SIG_W         = 14;
    localparam int BIAS          = 15;
    localparam int MAX_SHIFT_DEF = 13;
    localparam logic [EXP_W-1:0] EXP_MAX = 5'd31;

    typedef enum logic [1:0] {IDLE, CLASSIFY, ALIGN, DONE} state_t;

    typedef enum logic [2:0] {ZERO, DENORM, NORM, INF, NAN} fp_class_t;

    // One alignment step: guard/round move down, the bit leaving S folds into S.
    function automatic logic [SIG_W-1:0] shift_sticky(input logic [SIG_W-1:0] s);
        return {1'b0, s[SIG_W-1:2], s[1] | s[0]};
    endfunction

endpackage

// File: rtl/fp16_operand_unpack_if.sv
// Operand/result handshake bundle between the operand source and fp16_operand_unpack.
// master drives the operand pair and result ready; slave is the unpacker.
interface fp16_operand_unpack_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic        sign_a;
    logic        sign_b;
    logic [4:0]  exp_a;
    logic [4:0]  exp_b;
    logic [4:0]  exp_half;
    logic [9:0]  mant_a;
    logic [9:0]  mant_b;
    logic [13:0] align_a;
    logic [13:0] align_b;
    logic        exc;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, sign_a, sign_b, exp_a, exp_b, exp_half,
        input  mant_a, mant_b, align_a, align_b, exc
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, sign_a, sign_b, exp_a, exp_b, exp_half,
        output mant_a, mant_b, align_a, align_b, exc
    );

endinterface

// File: rtl/fp16_classify.sv
// Combinational field decode of one packed binary16 operand.
// Optional FP16_UNPACK_DAZ_EN flushes denormals to signed zero.
module fp16_classify
    import fp16_pkg::*;
(
    input  logic [15:0]       op,
    output logic              sign,
    output logic [EXP_W-1:0]  exp_field,
    output logic [FRAC_W-1:0] frac,
    output logic [EXP_W-1:0]  eff_exp,
    output logic              hidden,
    output fp_class_t         cls
);

    always_comb begin
        sign      = op[15];
        exp_field = op[14:10];
        frac      = op[9:0];
        hidden    = (exp_field != '0);
        eff_exp   = (exp_field == '0) ? 5'd1 : exp_field;
        if (exp_field == '0) begin
            cls = (frac == '0) ? ZERO : DENORM;
        end else if (exp_field == EXP_MAX) begin
            cls = (frac == '0) ? INF : NAN;
        end else begin
            cls = NORM;
        end
`ifdef FP16_UNPACK_DAZ_EN
        if (cls == DENORM) begin
            frac = '0;
            cls  = ZERO;
        end
`endif
    end

endmodule

// File: rtl/fp16_operand_unpack.sv
// Captures an FP16 operand pair, decodes both and aligns the smaller significand
// one bit per cycle. Build option FP16_UNPACK_DAZ_EN is handled in fp16_classify.
module fp16_operand_unpack
    import fp16_pkg::*;
#(
    parameter int MAX_SHIFT = MAX_SHIFT_DEF
) (
    input logic                  clk,
    input logic                  rst_n,
    fp16_operand_unpack_if.slave bus
);

    localparam logic [EXP_W-1:0] MAX_SHIFT_E = EXP_W'(MAX_SHIFT);
    localparam logic [3:0]       MAX_SHIFT_C = 4'(MAX_SHIFT);

    state_t            state_reg, state_next;
    logic [15:0]       op_reg    [2];
    logic [SIG_W-1:0]  align_reg [2];
    logic [EXP_W-1:0]  exp_half_reg;
    logic              exc_reg;
    logic              shift_a_reg;
    logic [3:0]        cnt_reg;

    logic              sign      [2];
    logic [EXP_W-1:0]  exp_field [2];
    logic [FRAC_W-1:0] frac      [2];
    logic [EXP_W-1:0]  eff_exp   [2];
    logic              hidden    [2];
    fp_class_t         cls       [2];
    logic [SIG_W-1:0]  sig       [2];

    logic              a_lt_b;
    logic [EXP_W-1:0]  diff;
    logic [3:0]        d_sat;
    logic [EXP_W-1:0]  exp_max;
    logic              exc_c;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            fp16_classify u_classify (
                .op        (op_reg[gi]),
                .sign      (sign[gi]),
                .exp_field (exp_field[gi]),
                .frac      (frac[gi]),
                .eff_exp   (eff_exp[gi]),
                .hidden    (hidden[gi]),
                .cls       (cls[gi])
            );
            assign sig[gi] = {hidden[gi], frac[gi], 3'b000};
        end
    endgenerate

    // Exponent compare; distances beyond MAX_SHIFT all reduce to a pure sticky bit.
    always_comb begin
        a_lt_b  = (eff_exp[0] < eff_exp[1]);
        diff    = a_lt_b ? (eff_exp[1] - eff_exp[0]) : (eff_exp[0] - eff_exp[1]);
        d_sat   = (diff > MAX_SHIFT_E) ? MAX_SHIFT_C : diff[3:0];
        exp_max = a_lt_b ? eff_exp[1] : eff_exp[0];
        exc_c   = (cls[0] == INF) || (cls[0] == NAN) || (cls[1] == INF) || (cls[1] == NAN);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (bus.in_valid) state_next = CLASSIFY;
            CLASSIFY: state_next = (exc_c || (diff == '0)) ? DONE : ALIGN;
            ALIGN:    if (cnt_reg == 4'd1) state_next = DONE;
            DONE:     if (bus.out_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            op_reg[0]    <= '0;
            op_reg[1]    <= '0;
            align_reg[0] <= '0;
            align_reg[1] <= '0;
            exp_half_reg <= '0;
            exc_reg      <= 1'b0;
            shift_a_reg  <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_reg[0] <= bus.in_a;
                        op_reg[1] <= bus.in_b;
                    end
                end
                CLASSIFY: begin
                    align_reg[0] <= sig[0];
                    align_reg[1] <= sig[1];
                    exp_half_reg <= exp_max;
                    exc_reg      <= exc_c;
                    shift_a_reg  <= a_lt_b;
                    cnt_reg      <= d_sat;
                end
                ALIGN: begin
                    if (shift_a_reg) align_reg[0] <= shift_sticky(align_reg[0]);
                    else             align_reg[1] <= shift_sticky(align_reg[1]);
                    cnt_reg <= cnt_reg - 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.sign_a    = sign[0];
    assign bus.sign_b    = sign[1];
    assign bus.exp_a     = exp_field[0];
    assign bus.exp_b     = exp_field[1];
    assign bus.mant_a    = frac[0];
    assign bus.mant_b    = frac[1];
    assign bus.exp_half  = exp_half_reg;
    assign bus.align_a   = align_reg[0];
    assign bus.align_b   = align_reg[1];
    assign bus.exc       = exc_reg;

endmodule
